// File: rtl/mul_share_arbiter.sv
// Two-requester front end for one shared sequential multiplier: round-robin grant,
// one job in flight, a bounded wait for completion and a one-cycle response pulse.
module mul_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,

    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_err,

    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_done,

    output logic                 busy
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic                 rr_ptr_q,  rr_ptr_d;
    logic                 owner_q,   owner_d;
    logic [WIDTH-1:0]     opa_q,     opa_d;
    logic [WIDTH-1:0]     opb_q,     opb_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 err_q,     err_d;

    logic                 grant0;
    logic                 grant1;

    // A lone requester always wins; on contention rr_ptr picks, so grants never overlap.
    assign grant0 = req0_valid && (!req1_valid || (rr_ptr_q == 1'b0));
    assign grant1 = req1_valid && (!req0_valid || (rr_ptr_q == 1'b1));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mul_start  = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is gated by reset so every output reads 0 while reset is held.
                req0_ready = rst && grant0;
                req1_ready = rst && grant1;
                if (grant0) begin
                    opa_d    = req0_a;
                    opb_d    = req0_b;
                    owner_d  = 1'b0;
                    rr_ptr_d = 1'b1;
                    state_d  = S_ISSUE;
                end else if (grant1) begin
                    opa_d    = req1_a;
                    opb_d    = req1_b;
                    owner_d  = 1'b1;
                    rr_ptr_d = 1'b0;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mul_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion wins over a timeout landing in the same cycle.
                if (mul_done) begin
                    product_d = mul_product;
                    err_d     = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    product_d = '0;
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                rsp0_valid = (owner_q == 1'b0);
                rsp1_valid = (owner_q == 1'b1);
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            err_q     <= err_d;
        end
    end

    assign mul_multiplicand = opa_q;
    assign mul_multiplier   = opb_q;
    assign rsp_product      = product_q;
    assign rsp_err          = err_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small latency-programmable multiplier
// model plus a manual mul_done path for ignore/timeout/reset corner cases.
module tb_mul_share_arbiter;

    localparam int W  = 16;
    localparam int TO = 20;

    logic           clk;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           rsp0_valid, rsp1_valid;
    logic [2*W-1:0] rsp_product;
    logic           rsp_err;
    logic           mul_start;
    logic [W-1:0]   mul_multiplicand, mul_multiplier;
    logic [2*W-1:0] mul_product;
    logic           mul_done;
    logic           busy;

    // multiplier model
    logic           model_en;
    int             lat;
    int             mcnt = 0;
    logic           mpend = 1'b0;
    logic           model_done = 1'b0;
    logic [2*W-1:0] model_prod = '0;
    logic [2*W-1:0] mlatch = '0;
    logic           man_done;
    logic [2*W-1:0] man_prod;

    int             n_cmp = 0;
    int             n_err = 0;
    logic           both_seen = 1'b0;

    int             cyc, starts, ngr, low, nrsp;
    logic           r0, r1;
    logic           gr [0:7];

    mul_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_a           (req0_a),
        .req0_b           (req0_b),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_a           (req1_a),
        .req1_b           (req1_b),
        .rsp0_valid       (rsp0_valid),
        .rsp1_valid       (rsp1_valid),
        .rsp_product      (rsp_product),
        .rsp_err          (rsp_err),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (mul_start) begin
            mpend  <= 1'b1;
            mcnt   <= lat;
            mlatch <= $signed(mul_multiplicand) * $signed(mul_multiplier);
        end else if (mpend) begin
            if (mcnt <= 1) begin
                model_done <= 1'b1;
                model_prod <= mlatch;
                mpend      <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    assign mul_done    = (model_en & model_done) | man_done;
    assign mul_product = model_en ? model_prod : man_prod;

    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic wait_rsp(input int limit, output int c, output logic v0, output logic v1,
                            output int st);
        c = -1; v0 = 1'b0; v1 = 1'b0; st = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mul_start) st++;
            if (rsp0_valid || rsp1_valid) begin
                c  = i;
                v0 = rsp0_valid;
                v1 = rsp1_valid;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_en = 1'b1; lat = 1; man_done = 1'b0; man_prod = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", mul_start, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rst_prod", rsp_product, 0);
        check("rst_err", rsp_err, 0);
        check("rst_opa", mul_multiplicand, 0);
        req0_valid = 1'b1;
        #1 check("rst_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;

        // single request 5 * -3, done on 17th WAIT cycle
        rst = 1'b1;
        @(negedge clk);
        lat = 16; req0_valid = 1'b1; req0_a = 16'sd5; req0_b = -16'sd3;
        #1 check("t1_rdy0", req0_ready, 1);
        check("t1_rdy1", req1_ready, 0);
        @(negedge clk);
        check("t1_start", mul_start, 1);
        check("t1_rdy_issue", req0_ready, 0);
        check("t1_opa", mul_multiplicand, 32'h0000_0005);
        check("t1_opb", mul_multiplier, 32'h0000_FFFD);
        req0_valid = 1'b0;
        wait_rsp(60, cyc, r0, r1, starts);
        check("t1_latency", cyc, 18);
        check("t1_rsp0", r0, 1);
        check("t1_rsp1", r1, 0);
        check("t1_extra_start", starts, 0);
        check("t1_prod", rsp_product, -15);
        check("t1_err", rsp_err, 0);
        check("t1_opa_hold", mul_multiplicand, 32'h0000_0005);
        @(negedge clk);
        check("t1_rsp_once", rsp0_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_prod_hold", rsp_product, -15);

        // both valid from first post-reset cycle; rr_ptr must restart at 0
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 16'sd7;  req0_b = 16'sd6;
        req1_valid = 1'b1; req1_a = -16'sd8; req1_b = 16'sd9;
        @(negedge clk);
        check("t2_rst_prod", rsp_product, 0);
        check("t2_rst_busy", busy, 0);
        lat = 2; rst = 1'b1;
        #1 check("t2_rdy0_first", req0_ready, 1);
        check("t2_rdy1_first", req1_ready, 0);
        @(negedge clk);
        check("t2_opa0", mul_multiplicand, 32'h0000_0007);
        req0_valid = 1'b0;
        wait_rsp(40, cyc, r0, r1, starts);
        check("t2_rsp0", r0, 1);
        check("t2_prod0", rsp_product, 42);
        @(negedge clk);
        check("t2_rdy1_second", req1_ready, 1);
        check("t2_rdy0_second", req0_ready, 0);
        @(negedge clk);
        check("t2_opa1", mul_multiplicand, 32'h0000_FFF8);
        req1_valid = 1'b0;
        wait_rsp(40, cyc, r0, r1, starts);
        check("t2_rsp1", r1, 1);
        check("t2_prod1", rsp_product, -72);

        // both held valid: eight alternating grants, one idle cycle between jobs
        lat = 1;
        req0_valid = 1'b1; req0_a = 16'sd2; req0_b = 16'sd3;
        req1_valid = 1'b1; req1_a = 16'sd4; req1_b = 16'sd5;
        ngr = 0; low = 0;
        for (int i = 0; i < 200 && ngr < 8; i++) begin
            @(negedge clk);
            if (!busy && ngr >= 1) low++;
            if (req0_ready) begin
                gr[ngr] = 1'b0; ngr++;
            end else if (req1_ready) begin
                gr[ngr] = 1'b1; ngr++;
            end
        end
        check("t3_grants", ngr, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_grant%0d", k), gr[k], k % 2);
        check("t3_busy_gaps", low, 7);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(40, cyc, r0, r1, starts);
        check("t3_last_rsp1", r1, 1);
        check("t3_last_prod", rsp_product, 20);

        // timeout on req1
        @(negedge clk);
        model_en = 1'b0;
        req1_valid = 1'b1; req1_a = 16'sd9; req1_b = 16'sd9;
        #1 check("t4_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check("t4_wait_busy", busy, 1);
        wait_rsp(TO + 10, cyc, r0, r1, starts);
        check("t4_timeout_lat", cyc, TO);
        check("t4_rsp1", r1, 1);
        check("t4_rsp0", r0, 0);
        check("t4_err", rsp_err, 1);
        check("t4_prod", rsp_product, 0);

        // mul_done on the timeout cycle counts as done
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'sd1; req0_b = 16'sd1;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        check("t5_no_rsp_yet", rsp0_valid, 0);
        man_prod = 32'd77; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t5_rsp0", rsp0_valid, 1);
        check("t5_err", rsp_err, 0);
        check("t5_prod", rsp_product, 77);

        // reset during WAIT aborts silently
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'sd3; req1_b = 16'sd3;
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("t6_rst_busy", busy, 0);
        check("t6_rst_opa", mul_multiplicand, 0);
        check("t6_rst_prod", rsp_product, 0);
        @(negedge clk);
        rst = 1'b1; man_prod = 32'd55; man_done = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            man_done = 1'b0;
            if (rsp0_valid || rsp1_valid || busy) nrsp++;
        end
        check("t6_no_rsp", nrsp, 0);
        model_en = 1'b1; lat = 3;
        req1_valid = 1'b1; req1_a = -16'sd4; req1_b = -16'sd6;
        #1 check("t6_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(40, cyc, r0, r1, starts);
        check("t6_rsp1", r1, 1);
        check("t6_prod", rsp_product, 24);

        // mul_done in IDLE and ISSUE is ignored
        @(negedge clk);
        model_en = 1'b0; man_prod = 32'd99; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t7_idle_ignore", {busy, rsp0_valid, rsp1_valid}, 0);
        req0_valid = 1'b1; req0_a = 16'sd3; req0_b = 16'sd11;
        @(negedge clk);
        req0_valid = 1'b0; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t7_issue_ignore", {busy, rsp0_valid}, 2'b10);
        nrsp = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) nrsp++;
        end
        check("t7_no_early_rsp", nrsp, 0);
        man_prod = 32'd33; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("t7_rsp0", rsp0_valid, 1);
        check("t7_prod", rsp_product, 33);
        check("t7_err", rsp_err, 0);

        check("never_both_ready", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; the product is 2*WIDTH.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the maximum number of WAIT cycles before an error response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 holds a multiply request.
REQ-006 req0_ready / req1_ready  output  1  request accepted this cycle, valid&&ready.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed multiplicand/multiplier per requester.
REQ-008 rsp0_valid / rsp1_valid  output  1  one-cycle response pulse to requester 0/1.
REQ-009 rsp_product  output  2*WIDTH  signed result, valid with rsp*_valid.
REQ-010 rsp_err  output  1  response is a timeout error, valid with rsp*_valid.
REQ-011 mul_start  output  1  start pulse to the shared sequential multiplier.
REQ-012 mul_multiplicand, mul_multiplier  output  WIDTH  operands to the multiplier.
REQ-013 mul_product  input  2*WIDTH  multiplier result.
REQ-014 mul_done  input  1  multiplier completion pulse.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; at most one request in flight.
REQ-017 Grant rules SHALL be combinational in IDLE only:
  - grant i when reqi_valid and the other requester is idle, or both are valid and rr_ptr==i.
  - reqi_ready = (state==IDLE) && grant i; never both ready in one cycle; both ready low outside IDLE.
REQ-018 On acceptance the block SHALL latch the operands, latch owner=i, set rr_ptr to the other requester, and go to ISSUE.
REQ-019 ISSUE SHALL last exactly one cycle with mul_start=1, then go to WAIT; mul_start SHALL be 0 in all other states.
REQ-020 mul_multiplicand/mul_multiplier SHALL drive the latched operands, stable from ISSUE through RESP.
REQ-021 WAIT SHALL clear the cycle counter on entry and increment it each cycle; mul_done SHALL be sampled only in WAIT and ignored in all other states.
REQ-022 WAIT with mul_done=1: latch mul_product, clear err, go to RESP.
REQ-023 WAIT with counter==TIMEOUT-1 and mul_done=0: latch product 0, set err=1, go to RESP.
REQ-024 mul_done and timeout in the same cycle SHALL be treated as done with err=0.
REQ-025 RESP SHALL assert rsp<owner>_valid for exactly one cycle with rsp_product/rsp_err, then return to IDLE.
REQ-026 rsp_product/rsp_err SHALL hold their last values until the next RESP.
REQ-027 Minimum request-to-response latency SHALL be accept cycle + 1 (ISSUE) + N WAIT cycles + 1 (RESP), where N is the number of WAIT cycles up to and including the mul_done cycle.
REQ-028 A new request SHALL be accepted no earlier than the cycle after RESP.
REQ-029 Requests deasserted before acceptance SHALL be dropped without effect.

Reset
REQ-030 While rst=0, the block SHALL force:
  - state=IDLE, rr_ptr=0, counter=0;
  - all outputs 0, including busy, mul_start, rsp*_valid, rsp_err, rsp_product, operands.
REQ-031 Reset asserted mid-operation (any state) SHALL abort the request with no response pulse; the first post-reset grant SHALL follow rr_ptr=0.

Verification
REQ-032 req0 only, a=5, b=-3; model returns -15 after 17 cycles -> req0_ready one cycle, single mul_start, rsp0_valid one cycle, rsp_product=-15, rsp_err=0.
REQ-033 req0 and req1 both valid from the first post-reset cycle (a0=7,b0=6; a1=-8,b1=9) -> req0 served first with product 42, then req1 with product -72; never both ready in one cycle.
REQ-034 Both requesters held valid for 4 requests each -> grants alternate 0,1,0,1,...; busy low for exactly one cycle between jobs.
REQ-035 req1 accepted, mul_done held 0 -> rsp1_valid exactly TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_product=0.
REQ-036 Reset pulsed during WAIT, then mul_done pulsed -> no rsp pulse, busy=0, next req1-only request is served normally.
REQ-037 mul_done pulsed during IDLE and ISSUE -> ignored; the response is produced only on the later in-WAIT mul_done.
